add_arbiter: RTL and testbench
==============================

# add_arbiter

Round-robin arbiter and sequencer that shares one registered adder datapath between `NUM_REQ` operand requesters. It accepts one operand pair per operation through a valid/ready handshake and drives the shared adder's operand and start signals. It captures the sum and overflow after a fixed latency and returns them to a single response port, tagged with the requester ID. It sits between the counter sources and the adder instance in the top-level design.

## Interface
- `WIDTH`, 32: operand and sum width.
- `NUM_REQ`, 4: number of requesters, 2..16.
- `LATENCY`, 1: adder latency in cycles from `o_add_start` to a valid `i_add_sum`, ≥1.
- `IDW` (localparam): `$clog2(NUM_REQ)`.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_req_valid`  in  NUM_REQ  per-requester operand valid.
- `o_req_ready`  out  NUM_REQ  per-requester accept, at most one bit set.
- `i_req_a`  in  NUM_REQ*WIDTH  operand A; requester k at `[k*WIDTH +: WIDTH]`.
- `i_req_b`  in  NUM_REQ*WIDTH  operand B; same packing.
- `o_add_a`  out  WIDTH  operand A to the adder.
- `o_add_b`  out  WIDTH  operand B to the adder.
- `o_add_start`  out  1  single-cycle operation strobe.
- `i_add_sum`  in  WIDTH  adder sum.
- `i_add_overflow`  in  1  adder carry-out.
- `o_rsp_valid`  out  1  response valid.
- `i_rsp_ready`  in  1  response accept.
- `o_rsp_id`  out  IDW  index of the requester that owns the response.
- `o_rsp_sum`  out  WIDTH  captured sum.
- `o_rsp_overflow`  out  1  captured overflow.

## Operation
- FSM states: IDLE, START, WAIT, RESP.
- Reset (async assert of `i_rst_n`, sync deassert at the top level):
  - State returns to IDLE.
  - All outputs go to 0.
  - RR pointer resets to NUM_REQ-1, so requester 0 wins first.
  - Latency counter resets to 0.
- IDLE:
  - `o_req_ready` is the combinational one-hot grant to the winner among `i_req_valid`.
  - Round-robin search starts at pointer+1 and wraps modulo NUM_REQ.
  - On grant: register the winner's operands into `o_add_a`/`o_add_b`, register the winner's ID, set the pointer to the winner, and go to START.
  - With no valid request, stay in IDLE with `o_req_ready`=0.
- START: `o_add_start`=1 for exactly this cycle; load the counter with LATENCY-1; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture `i_add_sum` and `i_add_overflow` into the `o_rsp_*` registers, set `o_rsp_valid`, and go to RESP.
- RESP:
  - Hold `o_rsp_*` stable while `i_rsp_ready`=0.
  - On `o_rsp_valid`&&`i_rsp_ready`: clear `o_rsp_valid` and go to IDLE.
  - No request is accepted in the handshake cycle.
- `o_req_ready` is 0 in every state except IDLE.
- Requesters keep valid and operands stable until accepted; requests are never dropped.
- `o_add_a`/`o_add_b` hold their values until the next grant.
- Reset mid-operation discards any in-flight operation and ignores adder output.
- Overflow is passed through unmodified; the block performs no arithmetic itself.

## Timing
- Grant in cycle T (IDLE, `o_req_ready[k]`=1).
- `o_add_start`=1 in cycle T+1.
- Sum is captured at the end of cycle T+1+LATENCY.
- `o_rsp_valid`=1 from cycle T+2+LATENCY.
- With `i_rsp_ready` held high, `o_rsp_valid` is high for one cycle, IDLE is reached at T+3+LATENCY, and the next grant can occur that cycle.
- Peak throughput: one operation per LATENCY+3 cycles.
- Ready depends combinationally on valid; valid must not depend on ready.

## Configuration
- `ADD_ARB_PRIO0_EN`:
  - Defined: requester 0 has strict priority and wins whenever `i_req_valid[0]`=1. Requesters 1..NUM_REQ-1 are round-robin among themselves. The pointer updates only on grants to requesters 1..NUM_REQ-1.
  - Undefined: pure round-robin across all requesters.

## Test plan
- Reset, single request: WIDTH=32, LATENCY=1; requester 2 sends a=5, b=7 with the adder model returning 12 → `o_req_ready`=4'b0100 in T, `o_add_start` in T+1, `o_rsp_valid` in T+3 with id=2, sum=12, overflow=0.
- Fairness: all four valid continuously, `i_rsp_ready`=1 → grant order 0,1,2,3,0,1; one grant every 4 cycles.
- Backpressure and overflow: a=32'hFFFF_FFFF, b=1 with the model returning 0/overflow=1; `i_rsp_ready` low for 5 cycles → response held stable (sum=0, overflow=1), no `o_req_ready` asserted, handshake on the 6th cycle.
- Latency sweep: LATENCY=3 → `o_add_start`→capture spacing is exactly 3 cycles; `o_rsp_valid` at T+5.
- Reset mid-WAIT: assert `i_rst_n`=0 one cycle after `o_add_start` → all outputs 0, no response issued; first post-reset grant goes to requester 0.
- `ADD_ARB_PRIO0_EN` defined, requesters 0 and 3 valid continuously → requester 0 granted every time; with requester 0 idle, requesters 1 and 3 alternate.

Source files
------------

// File: rtl/add_arbiter.sv
// add_arbiter: round-robin sequencer sharing one registered adder among NUM_REQ requesters.
// Optional macro ADD_ARB_PRIO0_EN gives requester 0 strict priority over the round-robin group.
module add_arbiter #(
   parameter  int WIDTH   = 32,
   parameter  int NUM_REQ = 4,
   parameter  int LATENCY = 1,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [NUM_REQ-1:0]       i_req_valid,
   output logic [NUM_REQ-1:0]       o_req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
   input  logic [NUM_REQ*WIDTH-1:0] i_req_b,
   output logic [WIDTH-1:0]         o_add_a,
   output logic [WIDTH-1:0]         o_add_b,
   output logic                     o_add_start,
   input  logic [WIDTH-1:0]         i_add_sum,
   input  logic                     i_add_overflow,
   output logic                     o_rsp_valid,
   input  logic                     i_rsp_ready,
   output logic [IDW-1:0]           o_rsp_id,
   output logic [WIDTH-1:0]         o_rsp_sum,
   output logic                     o_rsp_overflow
);

   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_e;

   state_e           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] add_a_q, add_a_d;
   logic [WIDTH-1:0] add_b_q, add_b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             ovf_q, ovf_d;
   logic             rsp_valid_q, rsp_valid_d;

   logic [NUM_REQ-1:0] rr_valid;
   logic [NUM_REQ-1:0] grant;
   logic [IDW-1:0]     win_id;
   logic [IDW-1:0]     scan;
   logic               found;
   logic [WIDTH-1:0]   req_a [NUM_REQ];
   logic [WIDTH-1:0]   req_b [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_a[g] = i_req_a[g*WIDTH +: WIDTH];
      assign req_b[g] = i_req_b[g*WIDTH +: WIDTH];
   end

   // Scan starts one past the last winner and wraps, so the last winner is checked last.
   always_comb begin
      rr_valid = i_req_valid;
`ifdef ADD_ARB_PRIO0_EN
      rr_valid[0] = 1'b0;
`endif
      found  = 1'b0;
      win_id = '0;
      scan   = ptr_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan = (scan == IDW'(NUM_REQ - 1)) ? '0 : scan + 1'b1;
         if (!found && rr_valid[scan]) begin
            found  = 1'b1;
            win_id = scan;
         end
      end
`ifdef ADD_ARB_PRIO0_EN
      if (i_req_valid[0]) begin
         found  = 1'b1;
         win_id = '0;
      end
`endif
      grant         = '0;
      grant[win_id] = found;
   end

   // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      cnt_d       = cnt_q;
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      sum_d       = sum_q;
      ovf_d       = ovf_q;
      rsp_valid_d = rsp_valid_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               add_a_d = req_a[win_id];
               add_b_d = req_b[win_id];
               id_d    = win_id;
`ifdef ADD_ARB_PRIO0_EN
               if (win_id != '0) ptr_d = win_id;
`else
               ptr_d   = win_id;
`endif
               state_d = START;
            end
         end
         START: begin
            cnt_d   = CW'(LATENCY - 1);
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == '0) begin
               sum_d       = i_add_sum;
               ovf_d       = i_add_overflow;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (i_rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so all registers update together from pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= IDW'(NUM_REQ - 1);
         id_q        <= '0;
         cnt_q       <= '0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         sum_q       <= '0;
         ovf_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         cnt_q       <= cnt_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         sum_q       <= sum_d;
         ovf_q       <= ovf_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign o_req_ready    = (state_q == IDLE) ? grant : '0;
   assign o_add_start    = (state_q == START);
   assign o_add_a        = add_a_q;
   assign o_add_b        = add_b_q;
   assign o_rsp_valid    = rsp_valid_q;
   assign o_rsp_id       = id_q;
   assign o_rsp_sum      = sum_q;
   assign o_rsp_overflow = ovf_q;

endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: directed vector tables, reset corner cases and a randomized run
// checked against a transaction-level model of the add_arbiter.
module tb_add_arbiter;

   localparam int WIDTH   = 32;
   localparam int NUM_REQ = 4;
   localparam int LAT     = 3;
   localparam int IDW     = $clog2(NUM_REQ);

   typedef struct packed {
      logic [NUM_REQ-1:0] mask;
      logic [WIDTH-1:0]   a;
      logic [WIDTH-1:0]   b;
      logic [NUM_REQ-1:0] grant;
      logic [WIDTH-1:0]   sum;
      logic               ovf;
      int                 stall;
   } vec_t;

   logic                     i_clk = 1'b0;
   logic                     i_rst_n = 1'b0;
   logic [NUM_REQ-1:0]       i_req_valid;
   logic [NUM_REQ-1:0]       o_req_ready;
   logic [NUM_REQ*WIDTH-1:0] i_req_a, i_req_b;
   logic [WIDTH-1:0]         o_add_a, o_add_b;
   logic                     o_add_start;
   logic [WIDTH-1:0]         i_add_sum;
   logic                     i_add_overflow;
   logic                     o_rsp_valid;
   logic                     i_rsp_ready = 1'b0;
   logic [IDW-1:0]           o_rsp_id;
   logic [WIDTH-1:0]         o_rsp_sum;
   logic                     o_rsp_overflow;

   logic             req_v [NUM_REQ];
   logic [WIDTH-1:0] req_a [NUM_REQ];
   logic [WIDTH-1:0] req_b [NUM_REQ];
   logic [WIDTH:0]   pipe  [LAT];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 i_clk = ~i_clk;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
      assign i_req_valid[g]            = req_v[g];
      assign i_req_a[g*WIDTH +: WIDTH] = req_a[g];
      assign i_req_b[g*WIDTH +: WIDTH] = req_b[g];
   end

   // Adder stand-in: a true sum LAT cycles after the strobe, junk on every other cycle.
   always @(posedge i_clk) begin
      pipe[0] <= o_add_start ? ({1'b0, o_add_a} + {1'b0, o_add_b}) : {1'b1, WIDTH'(32'hDEAD_BEEF)};
      for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
   end
   assign i_add_sum      = pipe[LAT-1][WIDTH-1:0];
   assign i_add_overflow = pipe[LAT-1][WIDTH];

   add_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .LATENCY(LAT)) u_dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_req_valid    (i_req_valid),
      .o_req_ready    (o_req_ready),
      .i_req_a        (i_req_a),
      .i_req_b        (i_req_b),
      .o_add_a        (o_add_a),
      .o_add_b        (o_add_b),
      .o_add_start    (o_add_start),
      .i_add_sum      (i_add_sum),
      .i_add_overflow (i_add_overflow),
      .o_rsp_valid    (o_rsp_valid),
      .i_rsp_ready    (i_rsp_ready),
      .o_rsp_id       (o_rsp_id),
      .o_rsp_sum      (o_rsp_sum),
      .o_rsp_overflow (o_rsp_overflow)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ready"}, o_req_ready, 0);
      check({tag, "_add_a"}, o_add_a, 0);
      check({tag, "_add_b"}, o_add_b, 0);
      check({tag, "_start"}, o_add_start, 0);
      check({tag, "_rsp_valid"}, o_rsp_valid, 0);
      check({tag, "_rsp_id"}, o_rsp_id, 0);
      check({tag, "_rsp_sum"}, o_rsp_sum, 0);
      check({tag, "_rsp_ovf"}, o_rsp_overflow, 0);
   endtask

   task automatic set_inputs(input logic [NUM_REQ-1:0] mask, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b);
      for (int k = 0; k < NUM_REQ; k++) begin
         req_v[k] = mask[k];
         req_a[k] = a + WIDTH'(k);
         req_b[k] = b;
      end
   endtask

   task automatic apply_reset();
      i_rst_n     = 1'b0;
      i_rsp_ready = 1'b0;
      set_inputs('0, '0, '0);
      tick();
      tick();
      check_zero("rst");
      i_rst_n = 1'b1;
   endtask

   // Requester k drives a+k and b; the record names the expected winner and its result.
   task automatic do_op(input vec_t v);
      int id = 0;
      set_inputs(v.mask, v.a, v.b);
      for (int k = 0; k < NUM_REQ; k++) if (v.grant[k]) id = k;
      i_rsp_ready = 1'b1;
      #1;
      check("grant", o_req_ready, v.grant);
      for (int t = 1; t <= LAT + 2 + v.stall; t++) begin
         tick();
         req_v[id]   = 1'b0;
         i_rsp_ready = !(t >= LAT + 2 && t < LAT + 2 + v.stall);
         #1;
         check("busy_ready", o_req_ready, 0);
         check("start", o_add_start, t == 1);
         check("rsp_valid", o_rsp_valid, t >= LAT + 2);
         if (t >= LAT + 2) begin
            check("rsp_id", o_rsp_id, id);
            check("rsp_sum", o_rsp_sum, v.sum);
            check("rsp_ovf", o_rsp_overflow, v.ovf);
         end
      end
      tick();
      check("rsp_clear", o_rsp_valid, 0);
   endtask

   function automatic vec_t mk(input logic [NUM_REQ-1:0] mask, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic [NUM_REQ-1:0] grant,
                               input logic [WIDTH-1:0] sum, input logic ovf, input int stall);
      vec_t v;
      v.mask = mask; v.a = a; v.b = b; v.grant = grant;
      v.sum = sum; v.ovf = ovf; v.stall = stall;
      return v;
   endfunction

   // Reference arbitration: first pending requester after the last winner, in wrap order.
   function automatic int pick(input logic [NUM_REQ-1:0] p, input int last);
`ifdef ADD_ARB_PRIO0_EN
      if (p[0]) return 0;
`endif
      for (int i = 1; i <= NUM_REQ; i++) begin
         int k = (last + i) % NUM_REQ;
`ifdef ADD_ARB_PRIO0_EN
         if (k == 0) continue;
`endif
         if (p[k]) return k;
      end
      return -1;
   endfunction

   bit               pend [NUM_REQ];
   logic [WIDTH-1:0] opa  [NUM_REQ];
   logic [WIDTH-1:0] opb  [NUM_REQ];

   initial begin
      vec_t tbl_a[$];
      vec_t tbl_b[$];
      vec_t tbl_p[$];
      logic [NUM_REQ-1:0] pv;
      logic [WIDTH-1:0]   e_sum;
      logic               e_ovf;
      int last, age, owner, w;

      tbl_a.push_back(mk(4'b0100, 32'd3,          32'd7,          4'b0100, 32'd12,         1'b0, 0));
      tbl_a.push_back(mk(4'b1111, 32'd100,        32'd200,        4'b1000, 32'd303,        1'b0, 0));
      tbl_a.push_back(mk(4'b1111, 32'hFFFF_FFF0,  32'h20,         4'b0001, 32'h10,         1'b1, 0));
      tbl_a.push_back(mk(4'b0011, 32'h1234_0000,  32'h5678,       4'b0010, 32'h1234_5679,  1'b0, 0));
      tbl_a.push_back(mk(4'b1001, 32'h7FFF_FFFD,  32'h7FFF_FFFF,  4'b1000, 32'hFFFF_FFFF,  1'b0, 0));
      tbl_a.push_back(mk(4'b0110, 32'd0,          32'd0,          4'b0010, 32'd1,          1'b0, 0));
      tbl_a.push_back(mk(4'b0001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'b0001, 32'hFFFF_FFFE,  1'b1, 0));
      tbl_a.push_back(mk(4'b1100, 32'd10,         32'd20,         4'b0100, 32'd32,         1'b0, 0));
      tbl_a.push_back(mk(4'b1010, 32'hFFFF_FFFC,  32'd1,          4'b1000, 32'd0,          1'b1, 5));
      tbl_a.push_back(mk(4'b1010, 32'd1,          32'd1,          4'b0010, 32'd3,          1'b0, 0));
      for (int i = 0; i < 6; i++)
         tbl_b.push_back(mk(4'b1111, 32'd1000, 32'd0, 4'b0001 << (i % 4), 32'd1000 + (i % 4), 1'b0, 0));
      tbl_p.push_back(mk(4'b1001, 32'd10, 32'd1, 4'b0001, 32'd11, 1'b0, 0));
      tbl_p.push_back(mk(4'b1001, 32'd20, 32'd2, 4'b0001, 32'd22, 1'b0, 0));
      tbl_p.push_back(mk(4'b1010, 32'd30, 32'd3, 4'b0010, 32'd34, 1'b0, 0));
      tbl_p.push_back(mk(4'b1010, 32'd40, 32'd4, 4'b1000, 32'd47, 1'b0, 0));
      tbl_p.push_back(mk(4'b1010, 32'd50, 32'd5, 4'b0010, 32'd56, 1'b0, 0));
      tbl_p.push_back(mk(4'b1011, 32'd60, 32'd6, 4'b0001, 32'd66, 1'b0, 0));
      tbl_p.push_back(mk(4'b1010, 32'd70, 32'd7, 4'b1000, 32'd80, 1'b0, 0));

      apply_reset();
`ifndef ADD_ARB_PRIO0_EN
      for (int i = 0; i < tbl_a.size(); i++) do_op(tbl_a[i]);

      // Reset one cycle after the start strobe: the operation must vanish without a response.
      set_inputs(4'b0100, 32'd40, 32'd2);
      i_rsp_ready = 1'b1;
      #1;
      check("mw_grant", o_req_ready, 4'b0100);
      tick();
      req_v[2] = 1'b0;
      #1;
      check("mw_start", o_add_start, 1);
      tick();
      i_rst_n = 1'b0;
      #1;
      check_zero("mw");
      tick();
      tick();
      i_rst_n = 1'b1;
      for (int t = 0; t < LAT + 3; t++) begin
         tick();
         check("mw_no_rsp", o_rsp_valid, 0);
         check("mw_no_start", o_add_start, 0);
      end
      for (int i = 0; i < tbl_b.size(); i++) do_op(tbl_b[i]);
`else
      for (int i = 0; i < tbl_p.size(); i++) do_op(tbl_p[i]);
`endif

      apply_reset();
      last = NUM_REQ - 1;
      age  = -1;
      owner = 0;
      e_sum = '0;
      e_ovf = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) pend[k] = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (!pend[k] && $urandom_range(0, 2) == 0) begin
               pend[k] = 1'b1;
               opa[k]  = $urandom;
               opb[k]  = $urandom;
            end
            req_v[k] = pend[k];
            req_a[k] = pend[k] ? opa[k] : $urandom;
            req_b[k] = pend[k] ? opb[k] : $urandom;
            pv[k]    = pend[k];
         end
         i_rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (age < 0) begin
            w = pick(pv, last);
            check("rnd_ready", o_req_ready, (w < 0) ? 0 : (1 << w));
            check("rnd_idle_start", o_add_start, 0);
            check("rnd_idle_rsp", o_rsp_valid, 0);
            if (w >= 0) begin
               pend[w] = 1'b0;
               owner   = w;
               {e_ovf, e_sum} = {1'b0, opa[w]} + {1'b0, opb[w]};
`ifdef ADD_ARB_PRIO0_EN
               if (w != 0) last = w;
`else
               last = w;
`endif
               age = 1;
            end
         end else begin
            check("rnd_busy_ready", o_req_ready, 0);
            check("rnd_start", o_add_start, age == 1);
            check("rnd_rsp_valid", o_rsp_valid, age >= LAT + 2);
            if (age >= LAT + 2) begin
               check("rnd_rsp_id", o_rsp_id, owner);
               check("rnd_rsp_sum", o_rsp_sum, e_sum);
               check("rnd_rsp_ovf", o_rsp_overflow, e_ovf);
            end
            if (age >= LAT + 2 && i_rsp_ready) age = -1;
            else age++;
         end
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
